// File: rtl/button_event_decoder.sv
// Debounces a raw button pin and emits one duration-tagged event per completed press over valid/ready.
// Define BUTTON_EVENT_REPEAT_EN to add auto-repeat events while a long press is held.
module button_event_decoder #(
    parameter int PRESCALE_TICKS = 240,
    parameter int DEBOUNCE_TICKS = 1000,
    parameter int LONG_TICKS     = 50000,
    parameter int DUR_W          = 17,
    parameter int REPEAT_TICKS   = 10000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_in,
    output logic             btn_level,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_long,
    output logic [DUR_W-1:0] evt_dur,
    output logic             evt_overrun
);

    // state      | meaning
    // IDLE       | debounced level low, waiting for the pin to rise
    // PRESS_DB   | pin high, confirming the press
    // HELD       | press confirmed, duration running
    // RELEASE_DB | pin low, confirming the release; duration still running
    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

    localparam int PW = (PRESCALE_TICKS > 1) ? $clog2(PRESCALE_TICKS) : 1;
    localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE_TICKS - 1);
    localparam logic [DW-1:0]    DB_LAST    = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [DUR_W-1:0] LONG_VAL   = DUR_W'(LONG_TICKS);

    if (PRESCALE_TICKS < 2 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1 ||
        LONG_TICKS < 1 || LONG_TICKS >= 2**DUR_W) begin : g_param_error
        $error("button_event_decoder: illegal parameter combination");
    end

    state_t           r_state, w_state_n;
    logic             r_sync1, r_sync2;
    logic [PW-1:0]    r_presc;
    logic [DW-1:0]    r_db_cnt, w_db_cnt_n;
    logic [DUR_W-1:0] r_dur, w_dur_n, w_dur_inc, w_emit_dur;
    logic             r_level, w_level_n;
    logic             r_evt_valid, r_evt_long, r_overrun;
    logic [DUR_W-1:0] r_evt_dur;
    logic             w_tick, w_timing, w_emit, w_emit_long, w_rep_hit, w_xfer;

    assign w_tick    = (r_presc == PRESC_LAST);
    assign w_timing  = (r_state == HELD) || (r_state == RELEASE_DB);
    assign w_dur_inc = (r_dur == '1) ? r_dur : r_dur + DUR_W'(1);
    assign w_xfer    = r_evt_valid && evt_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_presc <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_n;
    end

    always_comb begin
        w_state_n   = r_state;
        w_db_cnt_n  = r_db_cnt;
        w_dur_n     = r_dur;
        w_level_n   = r_level;
        w_emit      = 1'b0;
        w_emit_long = 1'b0;
        w_emit_dur  = w_dur_inc;
        if (w_tick && w_timing) w_dur_n = w_dur_inc;
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_state_n  = PRESS_DB;
                    w_db_cnt_n = '0;
                end
            end
            PRESS_DB: begin
                if (!r_sync2) begin
                    w_state_n  = IDLE;
                    w_db_cnt_n = '0;
                end else if (w_tick) begin
                    if (r_db_cnt == DB_LAST) begin
                        w_state_n  = HELD;
                        w_level_n  = 1'b1;
                        w_dur_n    = '0;
                        w_db_cnt_n = '0;
                    end else begin
                        w_db_cnt_n = r_db_cnt + DW'(1);
                    end
                end
            end
            HELD: begin
                if (!r_sync2) begin
                    w_state_n  = RELEASE_DB;
                    w_db_cnt_n = '0;
                end
            end
            RELEASE_DB: begin
                if (r_sync2) begin
                    w_state_n = HELD;
                end else if (w_tick) begin
                    if (r_db_cnt == DB_LAST) begin
                        w_state_n   = IDLE;
                        w_level_n   = 1'b0;
                        w_db_cnt_n  = '0;
                        w_emit      = 1'b1;
                        w_emit_long = (w_dur_inc >= LONG_VAL);
                    end else begin
                        w_db_cnt_n = r_db_cnt + DW'(1);
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
        // A repeat landing on the release-confirm tick is folded into the release event.
        if (w_rep_hit && !w_emit) begin
            w_emit      = 1'b1;
            w_emit_long = 1'b1;
        end
    end

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [RW-1:0]    REP_LAST  = RW'(REPEAT_TICKS - 1);
    localparam logic [DUR_W-1:0] LONG_PREV = DUR_W'(LONG_TICKS - 1);

    logic [RW-1:0] r_rep_cnt, w_rep_cnt_n;

    always_comb begin
        w_rep_cnt_n = r_rep_cnt;
        w_rep_hit   = 1'b0;
        if (w_tick && w_timing) begin
            if (r_dur == LONG_PREV) begin
                w_rep_hit   = 1'b1;
                w_rep_cnt_n = '0;
            end else if (r_dur >= LONG_VAL) begin
                if (r_rep_cnt == REP_LAST) begin
                    w_rep_hit   = 1'b1;
                    w_rep_cnt_n = '0;
                end else begin
                    w_rep_cnt_n = r_rep_cnt + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rep_cnt <= '0;
        else       r_rep_cnt <= w_rep_cnt_n;
    end
`else
    assign w_rep_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db_cnt    <= '0;
            r_dur       <= '0;
            r_level     <= 1'b0;
            r_evt_valid <= 1'b0;
            r_evt_long  <= 1'b0;
            r_evt_dur   <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_db_cnt <= w_db_cnt_n;
            r_dur    <= w_dur_n;
            r_level  <= w_level_n;
            if (w_emit && (!r_evt_valid || w_xfer)) begin
                r_evt_valid <= 1'b1;
                r_evt_long  <= w_emit_long;
                r_evt_dur   <= w_emit_dur;
            end else if (w_emit) begin
                r_overrun <= 1'b1;
            end else if (w_xfer) begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    assign btn_level   = r_level;
    assign evt_valid   = r_evt_valid;
    assign evt_long    = r_evt_long;
    assign evt_dur     = r_evt_dur;
    assign evt_overrun = r_overrun;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: tick-level behavioural model compared every cycle, plus directed literal checks.
module tb_button_event_decoder;

    localparam int P    = 4;
    localparam int DEB  = 3;
    localparam int LONG = 20;
    localparam int REP  = 5;
    localparam int DMAX = 255;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_in;
    logic       btn_level;
    logic       evt_valid;
    logic       evt_ready;
    logic       evt_long;
    logic [7:0] evt_dur;
    logic       evt_overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_event_decoder #(
        .PRESCALE_TICKS(P),
        .DEBOUNCE_TICKS(DEB),
        .LONG_TICKS    (LONG),
        .DUR_W         (8),
        .REPEAT_TICKS  (REP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_long   (evt_long),
        .evt_dur    (evt_dur),
        .evt_overrun(evt_overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: level flips once the pin has disagreed with it for DEB ticks (first disagreeing cycle
    // does not count); duration = ticks seen while the level is high.
    int         m_cyc, m_run_ticks, m_dur, s_edur;
    logic       m_h1, m_h2, m_level, m_run, m_tick;
    logic       s_sync, s_tick, s_conf, s_emit, s_xfer;
    logic       e_valid, e_long, e_over;
    logic [7:0] e_dur;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cyc = 0; m_run_ticks = 0; m_dur = 0;
            m_h1 = 0; m_h2 = 0; m_level = 0; m_run = 0; m_tick = 0;
            e_valid = 0; e_long = 0; e_over = 0; e_dur = 0;
        end else begin
            s_sync = m_h2; m_h2 = m_h1; m_h1 = btn_in;
            s_tick = ((m_cyc % P) == P - 1);
            m_cyc++;
            m_tick = s_tick;
            s_conf = 0; s_emit = 0; s_edur = 0;
            if (m_level && s_tick) m_dur++;
            if (s_sync != m_level) begin
                if (!m_run) begin
                    m_run = 1; m_run_ticks = 0;
                end else if (s_tick) begin
                    m_run_ticks++;
                    s_conf = (m_run_ticks == DEB);
                end
            end else begin
                m_run = 0;
            end
            if (s_conf) begin
                m_run = 0;
                if (m_level) begin s_emit = 1; s_edur = m_dur; end
                else m_dur = 0;
                m_level = !m_level;
            end
`ifdef BUTTON_EVENT_REPEAT_EN
            if (!s_emit && m_level && s_tick && m_dur >= LONG && ((m_dur - LONG) % REP) == 0) begin
                s_emit = 1; s_edur = m_dur;
            end
`endif
            s_xfer = e_valid && evt_ready;
            if (s_emit && (!e_valid || s_xfer)) begin
                e_valid = 1;
                e_dur   = 8'((s_edur > DMAX) ? DMAX : s_edur);
                e_long  = (s_edur >= LONG);
            end else if (s_emit) begin
                e_over = 1;
            end else if (s_xfer) begin
                e_valid = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("btn_level", 32'(btn_level), 32'(m_level));
        check("evt_valid", 32'(evt_valid), 32'(e_valid));
        check("evt_dur", 32'(evt_dur), 32'(e_dur));
        check("evt_long", 32'(evt_long), 32'(e_long));
        check("evt_overrun", 32'(evt_overrun), 32'(e_over));
    end

    // Log of events actually transferred by the DUT, for literal checks.
    typedef struct packed { logic [31:0] dur; logic lng; } ev_t;
    ev_t xq[$];

    always @(posedge clk) begin
        ev_t e;
        if (!reset && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            e.dur = 32'(evt_dur);
            e.lng = evt_long;
            xq.push_back(e);
        end
    end

    function automatic ev_t get_ev(input int idx);
        ev_t e;
        e.dur = 32'hFFFF_FFFF;
        e.lng = 1'b0;
        if (idx >= 0 && idx < xq.size()) e = xq[idx];
        return e;
    endfunction

    task automatic wait_level(input logic v, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (btn_level === v) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_level: btn_level still %0b, expected %0b within %0d cycles", btn_level, v, budget);
    endtask

    task automatic wait_ticks(input int n);
        int seen = 0;
        while (seen < n) begin
            @(negedge clk);
            if (m_tick) seen++;
        end
    endtask

    task automatic do_press(input int held_ticks);
        @(negedge clk);
        btn_in = 1'b1;
        wait_level(1'b1, 200);
        wait_ticks(held_ticks);
        btn_in = 1'b0;
        wait_level(1'b0, 200);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        ev_t e;
        reset = 1'b1; btn_in = 1'b0; evt_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_level", 32'(btn_level), 32'd0);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_dur", 32'(evt_dur), 32'd0);
        check("rst_overrun", 32'(evt_overrun), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // clean press: 10 ticks held + 3 release-debounce ticks
        xq.delete();
        do_press(10);
        check("clean_count", 32'(xq.size()), 32'd1);
        e = get_ev(0);
        check("clean_dur", e.dur, 32'd13);
        check("clean_long", 32'(e.lng), 32'd0);

        // bounce: short high, short low, high again
        xq.delete();
        @(negedge clk); btn_in = 1'b1;
        repeat (8) @(negedge clk);
        btn_in = 1'b0;
        repeat (4) @(negedge clk);
        check("bounce_level_lo", 32'(btn_level), 32'd0);
        btn_in = 1'b1;
        repeat (6) @(negedge clk);
        check("bounce_restart", 32'(btn_level), 32'd0);
        check("bounce_no_evt", 32'(xq.size()), 32'd0);
        wait_level(1'b1, 200);
        wait_ticks(4);
        btn_in = 1'b0;
        wait_level(1'b0, 200);
        repeat (3) @(negedge clk);
        check("bounce_count", 32'(xq.size()), 32'd1);
        e = get_ev(0);
        check("bounce_dur", e.dur, 32'd7);

        // long press saturates the 8-bit duration
        xq.delete();
        do_press(300);
`ifndef BUTTON_EVENT_REPEAT_EN
        check("long_count", 32'(xq.size()), 32'd1);
`endif
        e = get_ev(xq.size() - 1);
        check("long_dur", e.dur, 32'd255);
        check("long_flag", 32'(e.lng), 32'd1);

        // backpressure: second event dropped, overrun sticky
        xq.delete();
        evt_ready = 1'b0;
        do_press(5);
        check("bp_valid1", 32'(evt_valid), 32'd1);
        check("bp_dur1", 32'(evt_dur), 32'd8);
        check("bp_over0", 32'(evt_overrun), 32'd0);
        do_press(7);
        check("bp_hold_dur", 32'(evt_dur), 32'd8);
        check("bp_over1", 32'(evt_overrun), 32'd1);
        @(negedge clk); evt_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_drained", 32'(evt_valid), 32'd0);
        check("bp_over_sticky", 32'(evt_overrun), 32'd1);
        check("bp_count", 32'(xq.size()), 32'd1);
        e = get_ev(0);
        check("bp_xfer_dur", e.dur, 32'd8);

        // reset while held: everything clears, no event afterwards
        xq.delete();
        @(negedge clk); btn_in = 1'b1;
        wait_level(1'b1, 200);
        wait_ticks(4);
        reset = 1'b1;
        #1;
        check("mid_rst_level", 32'(btn_level), 32'd0);
        check("mid_rst_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_over", 32'(evt_overrun), 32'd0);
        check("mid_rst_dur", 32'(evt_dur), 32'd0);
        btn_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_rst_no_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_no_xfer", 32'(xq.size()), 32'd0);

        // second release confirms on the same edge the first event is accepted
        xq.delete();
        evt_ready = 1'b0;
        do_press(4);
        @(negedge clk); btn_in = 1'b1;
        wait_level(1'b1, 200);
        wait_ticks(6);
        btn_in = 1'b0;
        repeat (11) @(negedge clk);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        check("sim_level", 32'(btn_level), 32'd0);
        check("sim_valid", 32'(evt_valid), 32'd1);
        check("sim_dur", 32'(evt_dur), 32'd9);
        check("sim_over", 32'(evt_overrun), 32'd0);
        check("sim_first", get_ev(0).dur, 32'd7);
        repeat (3) @(negedge clk);
        evt_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("sim_drained", 32'(evt_valid), 32'd0);
        check("sim_count", 32'(xq.size()), 32'd2);
        check("sim_second", get_ev(1).dur, 32'd9);

`ifdef BUTTON_EVENT_REPEAT_EN
        xq.delete();
        do_press(32);
        check("rep_count", 32'(xq.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            e = get_ev(i);
            check("rep_dur", e.dur, 32'(20 + 5 * i));
            check("rep_long", 32'(e.lng), 32'd1);
        end
`endif

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: bench did not complete, got timeout, expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
